// File: rtl/bcd_stats_formatter_if.sv
// Request/result bundle between the game-state counters and the BCD formatter.
//   start      request a conversion of fields_in (honoured only when idle)
//   fields_in  NUM_FIELDS packed unsigned values, field i at [i*WIDTH +: WIDTH]
//   busy       conversion in progress
//   done       one-cycle pulse when bcd_out/lz_mask/overflow were refreshed
//   bcd_out    DIGITS BCD digits per field, digit j of field i at [(i*DIGITS+j)*4 +: 4]
//   lz_mask    1 = digit is a leading zero and should be blanked
//   overflow   field exceeded the displayable range and was saturated to all 9s
// master = requester (game logic / testbench), slave = formatter.
interface bcd_stats_formatter_if #(
  parameter int NUM_FIELDS = 3,
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 2
);
  logic                           start;
  logic [NUM_FIELDS*WIDTH-1:0]    fields_in;
  logic                           busy;
  logic                           done;
  logic [NUM_FIELDS*DIGITS*4-1:0] bcd_out;
  logic [NUM_FIELDS*DIGITS-1:0]   lz_mask;
  logic [NUM_FIELDS-1:0]          overflow;

  modport master (
    output start, fields_in,
    input  busy, done, bcd_out, lz_mask, overflow
  );

  modport slave (
    input  start, fields_in,
    output busy, done, bcd_out, lz_mask, overflow
  );
endinterface

// File: rtl/bcd_stats_formatter.sv
// Sequential binary-to-BCD converter for end-of-game statistics. One shared
// double-dabble engine converts NUM_FIELDS values one after another, saturates
// values above 10^DIGITS-1 to all 9s, derives leading-zero blanking masks and
// publishes all results on a single edge so the overlay never shows a mixed frame.
// Ports:
//   pclk  pixel clock, all logic on the rising edge
//   rst   synchronous active-high reset (wins over start)
//   bus   slave side of bcd_stats_formatter_if (start/fields_in in,
//         busy/done/bcd_out/lz_mask/overflow out)
module bcd_stats_formatter #(
  parameter int NUM_FIELDS = 3,
  parameter int WIDTH      = 8,
  parameter int DIGITS     = 2
) (
  input  logic                 pclk,
  input  logic                 rst,
  bcd_stats_formatter_if.slave bus
);

  function automatic longint unsigned calc_max_val(input int digits);
    longint unsigned v;
    v = 1;
    for (int k = 0; k < digits; k++) v = v * 10;
    return v - 1;
  endfunction

  // Per field: every digit except the units digit blanked, so 0 shows as "0".
  function automatic logic [NUM_FIELDS*DIGITS-1:0] lz_reset_val();
    logic [NUM_FIELDS*DIGITS-1:0] v;
    v = '0;
    for (int f = 0; f < NUM_FIELDS; f++)
      for (int j = 1; j < DIGITS; j++) v[f*DIGITS+j] = 1'b1;
    return v;
  endfunction

  localparam longint unsigned MAX_VAL = calc_max_val(DIGITS);
  localparam int ACC_W = DIGITS * 4;
  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [NUM_FIELDS*DIGITS-1:0] LZ_RESET = lz_reset_val();
  localparam logic [ACC_W-1:0] SAT_VAL = {DIGITS{4'h9}};

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]               shadow_reg [NUM_FIELDS];
  logic [IDX_W-1:0]               idx_reg;
  logic [CNT_W-1:0]               cnt_reg;
  logic [WIDTH-1:0]               shreg_reg;
  logic [ACC_W-1:0]               acc_reg;
  logic                           ovf_reg;
  logic [NUM_FIELDS*ACC_W-1:0]    stage_bcd_reg;
  logic [NUM_FIELDS-1:0]          stage_ovf_reg;
  logic [NUM_FIELDS*ACC_W-1:0]    bcd_reg;
  logic [NUM_FIELDS*DIGITS-1:0]   lz_reg;
  logic [NUM_FIELDS-1:0]          ovf_out_reg;
  logic                           done_reg;

  logic [WIDTH-1:0]               cur_field;
  logic                           field_ovf;
  logic [ACC_W-1:0]               acc_adj;
  logic [NUM_FIELDS*DIGITS-1:0]   lz_calc;

  // Field currently being converted, taken from the snapshot, not the live input.
  always_comb begin
    cur_field = '0;
    for (int f = 0; f < NUM_FIELDS; f++)
      if (idx_reg == IDX_W'(f)) cur_field = shadow_reg[f];
  end

  assign field_ovf = (64'(cur_field) > MAX_VAL);

  // Double-dabble correction: digits >= 5 get +3 before the shift.
  // A top digit pushed past 9 only happens for saturated fields, whose
  // accumulator is discarded anyway.
  genvar gi, gj;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end

    // Digit j is a leading zero when it and every digit above it are zero.
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_lz
      assign lz_calc[gi*DIGITS] = 1'b0;
      for (gj = 1; gj < DIGITS; gj++) begin : g_dig
        assign lz_calc[gi*DIGITS+gj] = ~stage_ovf_reg[gi] &&
            (stage_bcd_reg[(gi*DIGITS+gj)*4 +: (DIGITS-gj)*4] == '0);
      end
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = STORE;
      STORE:   state_next = (idx_reg == IDX_W'(NUM_FIELDS - 1)) ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      idx_reg       <= '0;
      cnt_reg       <= '0;
      shreg_reg     <= '0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      stage_bcd_reg <= '0;
      stage_ovf_reg <= '0;
      bcd_reg       <= '0;
      lz_reg        <= LZ_RESET;
      ovf_out_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            for (int f = 0; f < NUM_FIELDS; f++)
              shadow_reg[f] <= bus.fields_in[f*WIDTH +: WIDTH];
            idx_reg <= '0;
          end
        end
        LOAD: begin
          shreg_reg <= cur_field;
          acc_reg   <= '0;
          cnt_reg   <= CNT_W'(WIDTH);
          ovf_reg   <= field_ovf;
        end
        SHIFT: begin
          {acc_reg, shreg_reg} <= {acc_adj, shreg_reg} << 1;
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        STORE: begin
          for (int f = 0; f < NUM_FIELDS; f++) begin
            if (idx_reg == IDX_W'(f)) begin
              stage_bcd_reg[f*ACC_W +: ACC_W] <= ovf_reg ? SAT_VAL : acc_reg;
              stage_ovf_reg[f]                <= ovf_reg;
            end
          end
          if (idx_reg != IDX_W'(NUM_FIELDS - 1)) idx_reg <= idx_reg + IDX_W'(1);
        end
        DONE: begin
          // Single-edge publish of every visible result.
          bcd_reg     <= stage_bcd_reg;
          ovf_out_reg <= stage_ovf_reg;
          lz_reg      <= lz_calc;
          done_reg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_reg == LOAD) || (state_reg == SHIFT) || (state_reg == STORE);
  assign bus.done     = done_reg;
  assign bus.bcd_out  = bcd_reg;
  assign bus.lz_mask  = lz_reg;
  assign bus.overflow = ovf_out_reg;

endmodule

// File: tb/tb_bcd_stats_formatter.sv
// Bench for bcd_stats_formatter: default instance (3 x 8-bit, 2 digits) checked
// every cycle against a decimal-arithmetic model, plus a 1 x 13-bit, 4-digit instance.
module tb_bcd_stats_formatter;

  localparam int NF   = 3;
  localparam int W    = 8;
  localparam int D    = 2;
  localparam int MAXV = 99;
  localparam int LAT  = NF * (W + 2) + 1;
  localparam logic [NF*D-1:0] LZ_RST = 6'b10_10_10;

  logic pclk;
  logic rst;
  int   check_cnt;
  int   pass_cnt;
  bit   check_en;
  int   txn_cnt;

  bcd_stats_formatter_if #(.NUM_FIELDS(NF), .WIDTH(W), .DIGITS(D)) a_if ();
  bcd_stats_formatter_if #(.NUM_FIELDS(1), .WIDTH(13), .DIGITS(4)) b_if ();

  bcd_stats_formatter #(.NUM_FIELDS(NF), .WIDTH(W), .DIGITS(D)) dut_a (
    .pclk(pclk), .rst(rst), .bus(a_if)
  );

  bcd_stats_formatter #(.NUM_FIELDS(1), .WIDTH(13), .DIGITS(4)) dut_b (
    .pclk(pclk), .rst(rst), .bus(b_if)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Decimal reference: digits by division, saturation to all 9s above MAXV,
  // digit j>=1 blanked exactly when the value is below 10^j.
  function automatic void model_conv(input logic [NF*W-1:0] f,
                                     output logic [NF*D*4-1:0] bcd,
                                     output logic [NF*D-1:0] lz,
                                     output logic [NF-1:0] ovf);
    int v;
    int p;
    bcd = '0;
    lz  = '0;
    ovf = '0;
    for (int i = 0; i < NF; i++) begin
      v = int'(f[i*W +: W]);
      if (v > MAXV) begin
        ovf[i] = 1'b1;
        for (int j = 0; j < D; j++) bcd[(i*D+j)*4 +: 4] = 4'd9;
      end else begin
        p = 1;
        for (int j = 0; j < D; j++) begin
          bcd[(i*D+j)*4 +: 4] = 4'((v / p) % 10);
          if (j > 0 && v < p) lz[i*D+j] = 1'b1;
          p = p * 10;
        end
      end
    end
  endfunction

  // Transaction-level model: an accepted request yields its result LAT edges
  // later; requests while a conversion is pending are dropped; reset clears all.
  int                m_cnt;
  logic [NF*D*4-1:0] p_bcd, exp_bcd;
  logic [NF*D-1:0]   p_lz, exp_lz;
  logic [NF-1:0]     p_ovf, exp_ovf;
  logic              exp_busy, exp_done;

  initial m_cnt = 0;

  always @(posedge pclk) begin
    exp_done = 1'b0;
    if (rst) begin
      m_cnt   = 0;
      exp_bcd = '0;
      exp_lz  = LZ_RST;
      exp_ovf = '0;
    end else if (m_cnt == 0) begin
      if (a_if.start) begin
        model_conv(a_if.fields_in, p_bcd, p_lz, p_ovf);
        m_cnt = LAT;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        exp_bcd  = p_bcd;
        exp_lz   = p_lz;
        exp_ovf  = p_ovf;
        exp_done = 1'b1;
      end
    end
    exp_busy = (m_cnt >= 2);
  end

  always @(negedge pclk) begin
    if (check_en) begin
      chk("busy", 64'(a_if.busy), 64'(exp_busy));
      chk("done", 64'(a_if.done), 64'(exp_done));
      chk("bcd_out", 64'(a_if.bcd_out), 64'(exp_bcd));
      chk("lz_mask", 64'(a_if.lz_mask), 64'(exp_lz));
      chk("overflow", 64'(a_if.overflow), 64'(exp_ovf));
      if (a_if.done) begin
        txn_cnt++;
        $display("txn %0d: bcd_out=%h lz_mask=%b overflow=%b", txn_cnt,
                 a_if.bcd_out, a_if.lz_mask, a_if.overflow);
      end
    end
  end

  function automatic logic [7:0] rand_field();
    case ($urandom_range(0, 4))
      0:       return 8'($urandom_range(0, 9));
      1:       return 8'($urandom_range(10, 99));
      2:       return 8'($urandom_range(100, 255));
      3:       return 8'd99;
      default: return 8'd100;
    endcase
  endfunction

  task automatic run_a(input logic [NF*W-1:0] f, output int lat);
    @(negedge pclk);
    a_if.fields_in = f;
    a_if.start     = 1'b1;
    @(negedge pclk);
    a_if.start = 1'b0;
    lat = 0;
    while (!a_if.done && lat < 200) begin
      @(negedge pclk);
      lat++;
    end
  endtask

  task automatic run_b(input logic [12:0] f, output int lat);
    @(negedge pclk);
    b_if.fields_in = f;
    b_if.start     = 1'b1;
    @(negedge pclk);
    b_if.start = 1'b0;
    lat = 0;
    while (!b_if.done && lat < 200) begin
      @(negedge pclk);
      lat++;
    end
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      @(negedge pclk);
      if (a_if.done) dones++;
    end
  endtask

  initial begin
    int lat;
    int dones;
    check_cnt      = 0;
    pass_cnt       = 0;
    txn_cnt        = 0;
    check_en       = 1'b0;
    rst            = 1'b1;
    a_if.start     = 1'b0;
    a_if.fields_in = '0;
    b_if.start     = 1'b0;
    b_if.fields_in = '0;
    repeat (3) @(negedge pclk);
    rst      = 1'b0;
    check_en = 1'b1;

    // Reset state, pinned literally.
    chk("rst_busy", 64'(a_if.busy), 64'd0);
    chk("rst_done", 64'(a_if.done), 64'd0);
    chk("rst_bcd", 64'(a_if.bcd_out), 64'd0);
    chk("rst_ovf", 64'(a_if.overflow), 64'd0);
    chk("rst_lz", 64'(a_if.lz_mask), 64'(6'b10_10_10));
    chk("b_rst_lz", 64'(b_if.lz_mask), 64'(4'b1110));

    // Basic conversion and latency.
    run_a({8'd7, 8'd42, 8'd99}, lat);
    chk("lat", 64'(lat), 64'd31);
    chk("t2_bcd", 64'(a_if.bcd_out), 64'h07_42_99);
    chk("t2_lz", 64'(a_if.lz_mask), 64'(6'b10_00_00));
    chk("t2_ovf", 64'(a_if.overflow), 64'd0);

    // Saturation, exact boundary 100, and zero.
    run_a({8'd0, 8'd100, 8'd150}, lat);
    chk("t3_bcd", 64'(a_if.bcd_out), 64'h00_99_99);
    chk("t3_ovf", 64'(a_if.overflow), 64'(3'b011));
    chk("t3_lz", 64'(a_if.lz_mask), 64'(6'b10_00_00));

    // Start and input changes during busy are ignored; one done pulse.
    @(negedge pclk);
    a_if.fields_in = {8'd7, 8'd42, 8'd99};
    a_if.start     = 1'b1;
    @(negedge pclk);
    a_if.start = 1'b0;
    repeat (4) @(negedge pclk);
    a_if.fields_in = {8'd1, 8'd2, 8'd3};
    a_if.start     = 1'b1;
    @(negedge pclk);
    a_if.start = 1'b0;
    count_dones(40, dones);
    chk("t4_dones", 64'(dones), 64'd1);
    chk("t4_bcd", 64'(a_if.bcd_out), 64'h07_42_99);

    // Reset mid-conversion aborts without a done pulse.
    @(negedge pclk);
    a_if.fields_in = {8'd5, 8'd6, 8'd7};
    a_if.start     = 1'b1;
    @(negedge pclk);
    a_if.start = 1'b0;
    repeat (9) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk("t5_busy", 64'(a_if.busy), 64'd0);
    chk("t5_bcd", 64'(a_if.bcd_out), 64'd0);
    chk("t5_lz", 64'(a_if.lz_mask), 64'(6'b10_10_10));
    count_dones(40, dones);
    chk("t5_dones", 64'(dones), 64'd0);
    run_a({8'd255, 8'd9, 8'd10}, lat);
    chk("t5_lat", 64'(lat), 64'd31);
    chk("t5_bcd2", 64'(a_if.bcd_out), 64'h99_09_10);
    chk("t5_ovf2", 64'(a_if.overflow), 64'(3'b100));
    chk("t5_lz2", 64'(a_if.lz_mask), 64'(6'b00_10_00));

    // Wide single-field instance.
    run_b(13'd8191, lat);
    chk("b_lat", 64'(lat), 64'd16);
    chk("b_bcd", 64'(b_if.bcd_out), 64'h8191);
    chk("b_lz", 64'(b_if.lz_mask), 64'(4'b0000));
    chk("b_ovf", 64'(b_if.overflow), 64'd0);
    run_b(13'd5, lat);
    chk("b_bcd5", 64'(b_if.bcd_out), 64'h0005);
    chk("b_lz5", 64'(b_if.lz_mask), 64'(4'b1110));

    // Random traffic: sporadic starts, inputs churning every cycle, rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk);
      a_if.start     = ($urandom_range(0, 5) == 0);
      a_if.fields_in = {rand_field(), rand_field(), rand_field()};
      rst            = ($urandom_range(0, 299) == 0);
    end
    @(negedge pclk);
    a_if.start = 1'b0;
    rst        = 1'b0;
    repeat (40) @(negedge pclk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
